// File: rtl/regfile_reader_if.sv
// Bus between the register-file reader and its environment: the request
// inputs, the register-file read port and the valid/ready result channel.
interface regfile_reader_if;
    logic        in_start;
    logic        in_mode;
    logic [3:0]  in_reg;
    logic [3:0]  out_Aselect;
    logic [31:0] in_Adata;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        out_valid;
    logic        in_ready;
    logic        out_busy;
    logic        out_done;

    // Environment side: issues requests, serves the register file, consumes results.
    modport master (
        output in_start, in_mode, in_reg, in_Adata, in_ready,
        input  out_Aselect, out_data, out_index, out_valid, out_busy, out_done
    );

    // Reader side.
    modport slave (
        input  in_start, in_mode, in_reg, in_Adata, in_ready,
        output out_Aselect, out_data, out_index, out_valid, out_busy, out_done
    );
endinterface

// File: rtl/regfile_reader.sv
// Register-file reader: reads one register, or dumps registers 0..LAST_REG,
// presenting each value on a valid/ready channel. All outputs are registered.
module regfile_reader #(
    parameter int LAST_REG = 15
) (
    input  logic             in_clk,
    input  logic             in_clr,
    regfile_reader_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEL     = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(LAST_REG);

    logic [1:0]  state_q, state_d;
    logic        mode_q, mode_d;
    logic [3:0]  sel_q, sel_d;       // current index, also drives out_Aselect
    logic [31:0] data_q, data_d;
    logic [3:0]  index_q, index_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state and next-output computation for the read sequencer.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    mode_d  = bus.in_mode;
                    sel_d   = bus.in_mode ? 4'd0 : bus.in_reg;
                    state_d = ST_SEL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                // Read data is combinational from sel_q, so it is valid here.
                data_d  = bus.in_Adata;
                index_d = sel_q;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.in_ready) begin
                    valid_d = 1'b0;
                    if (!mode_q || (sel_q == LAST_IDX)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        sel_d   = sel_q + 4'd1;
                        state_d = ST_SEL;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge in_clk) begin
        if (in_clr) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            sel_q   <= 4'd0;
            data_q  <= 32'd0;
            index_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_Aselect = sel_q;
    assign bus.out_data    = data_q;
    assign bus.out_index   = index_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_busy    = busy_q;
    assign bus.out_done    = done_q;

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter: LAST_REG, 15, highest register index read in dump mode (legal 0..15).
REQ-002 SHALL have port: in_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: in_clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: in_mode  input  1  0 = single-register read, 1 = dump registers 0..LAST_REG; sampled with in_start.
REQ-006 SHALL have port: in_reg  input  4  register index for single mode; sampled with in_start.
REQ-007 SHALL have port: out_Aselect  output  4  register file read select.
REQ-008 SHALL have port: in_Adata  input  32  register file read data, combinational from out_Aselect.
REQ-009 SHALL have port: out_data  output  32  captured register value.
REQ-010 SHALL have port: out_index  output  4  index of the value on out_data.
REQ-011 SHALL have port: out_valid  output  1  out_data/out_index valid.
REQ-012 SHALL have port: in_ready  input  1  consumer accepts; transfer when out_valid & in_ready at a rising edge.
REQ-013 SHALL have port: out_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port: out_done  output  1  one-cycle pulse after final transfer.

Function
REQ-015 SHALL implement FSM states IDLE, SEL, PRESENT, DONE; all outputs registered.
REQ-016 IDLE: on in_start=1, SHALL latch mode, load index (in_reg if single, 0 if dump), drive out_Aselect=index, go to SEL.
REQ-017 SEL: SHALL capture in_Adata into out_data, index into out_index, set out_valid=1, go to PRESENT (one cycle in SEL).
REQ-018 PRESENT: while in_ready=0, SHALL hold out_data, out_index, out_valid=1 unchanged.
REQ-019 PRESENT with in_ready=1: SHALL clear out_valid; if single mode or index==LAST_REG go to DONE, else index+1, out_Aselect=index+1, go to SEL.
REQ-020 DONE: SHALL assert out_done for exactly one cycle and return to IDLE.
REQ-021 Latency: start at edge k -> out_valid high after edge k+2; minimum 2 cycles per register in dump mode (SEL + PRESENT with in_ready=1).
REQ-022 in_start while out_busy=1 SHALL be ignored; no queuing.
REQ-023 in_start and in_ready both high in IDLE: in_ready SHALL have no effect.
REQ-024 Index SHALL never wrap past LAST_REG; LAST_REG=0 in dump mode yields exactly one transfer (index 0).
REQ-025 LAST_REG SHALL be ignored in single mode; in_reg=15 legal.
REQ-026 Changes of in_mode/in_reg after start SHALL not affect the operation in progress.
REQ-027 out_Aselect SHALL hold its last value in IDLE and DONE.

Reset
REQ-028 in_clr=1 at a rising edge SHALL force IDLE, out_Aselect=0, out_data=0, out_index=0, out_valid=0, out_busy=0, out_done=0, from any state.
REQ-029 in_clr SHALL take priority over in_start and in_ready in the same cycle; a dump aborted by reset SHALL not produce out_done.

Verification
REQ-030 Single read: reg 5 = 0x11110000, in_mode=0, in_reg=5, start, in_ready=1 -> one transfer out_index=5, out_data=0x11110000, out_done pulse 1 cycle later.
REQ-031 Dump: registers loaded with 0x1000_000i (i = 0..15), LAST_REG=15, in_ready=1 -> 16 transfers indices 0..15 in order with matching data, single out_done, out_busy low after.
REQ-032 Backpressure: dump, in_ready=0 for 4 cycles at index 3 -> out_valid stays 1, out_data=0x10000003 stable, no index skipped or repeated.
REQ-033 Start while busy: second in_start mid-dump with in_reg=9, in_mode=0 -> ignored; dump completes unchanged, no extra transfer.
REQ-034 Reset mid-dump: in_clr=1 during PRESENT at index 7 -> next cycle out_valid=0, out_busy=0, out_data=0, no out_done; subsequent start works normally.
REQ-035 LAST_REG=0 dump -> exactly one transfer, index 0, then out_done.
